// File: rtl/frame_buffer.sv
// Row-major pixel store, one write and one registered read per cycle (1-cycle latency, write-through on same-cycle RE+WE).
// No backpressure: strobes are sampled every cycle; out-of-range addresses drop writes and read as zero.
module frame_buffer #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic [$clog2(P_COLUMNS)-1:0] I_COLUMN,
    input  logic [$clog2(P_ROWS)-1:0]    I_ROW,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    input  logic                         I_WRITE_ENABLE,
    input  logic                         I_READ_ENABLE,
    output logic [P_PIXEL_DEPTH-1:0]     O_PIXEL
);

    localparam int COL_W = $clog2(P_COLUMNS);
    localparam int ROW_W = $clog2(P_ROWS);
    localparam int DEPTH = P_COLUMNS * P_ROWS;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [COL_W:0] COL_LIMIT = P_COLUMNS[COL_W:0];
    localparam logic [ROW_W:0] ROW_LIMIT = P_ROWS[ROW_W:0];

    logic [P_PIXEL_DEPTH-1:0] mem [DEPTH];
    logic                     addr_valid;
    logic [IDX_W-1:0]         lin_idx;
    logic [P_PIXEL_DEPTH-1:0] pixel_q;
    logic [P_PIXEL_DEPTH-1:0] pixel_next;

    // Extra top bit on each comparison keeps the limit representable when it is a power of two.
    assign addr_valid = ({1'b0, I_COLUMN} < COL_LIMIT) && ({1'b0, I_ROW} < ROW_LIMIT);
    assign lin_idx    = IDX_W'(I_ROW) * IDX_W'(P_COLUMNS) + IDX_W'(I_COLUMN);

    // Storage has no reset so it maps onto plain RAM and survives a reset pulse.
    always_ff @(posedge I_CLK) begin
        if (I_RESET && I_WRITE_ENABLE && addr_valid) begin
            mem[lin_idx] <= I_PIXEL;
        end
    end

    always_comb begin
        pixel_next = '0;
        if (addr_valid) begin
            pixel_next = I_WRITE_ENABLE ? I_PIXEL : mem[lin_idx];
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            pixel_q <= '0;
        end else if (I_READ_ENABLE) begin
            pixel_q <= pixel_next;
        end
    end

    assign O_PIXEL = pixel_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: a per-cycle model/compare plus literal spot checks.
module tb_frame_buffer;

    localparam int COLS = 640;
    localparam int ROWS = 3;

    logic        I_CLK;
    logic        I_RESET;
    logic [9:0]  I_COLUMN;
    logic [1:0]  I_ROW;
    logic [23:0] I_PIXEL;
    logic        I_WRITE_ENABLE;
    logic        I_READ_ENABLE;
    logic [23:0] O_PIXEL;

    int n_chk  = 0;
    int n_fail = 0;

    frame_buffer #(.P_COLUMNS(COLS), .P_ROWS(ROWS), .P_PIXEL_DEPTH(24)) dut (
        .I_CLK          (I_CLK),
        .I_RESET        (I_RESET),
        .I_COLUMN       (I_COLUMN),
        .I_ROW          (I_ROW),
        .I_PIXEL        (I_PIXEL),
        .I_WRITE_ENABLE (I_WRITE_ENABLE),
        .I_READ_ENABLE  (I_READ_ENABLE),
        .O_PIXEL        (O_PIXEL)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // Reference model: storage as a sparse map of written pixels keyed by (row, column).
    logic [23:0] m_mem [int];
    logic [23:0] m_out   = '0;
    bit          m_known = 1'b0;

    always @(posedge I_CLK or negedge I_RESET) begin
        int  col, row, key;
        bit  in_range;
        if (!I_RESET) begin
            m_out   = '0;
            m_known = 1'b1;
        end else begin
            col      = int'(I_COLUMN);
            row      = int'(I_ROW);
            in_range = (col < COLS) && (row < ROWS);
            key      = row * COLS + col;
            if (I_READ_ENABLE) begin
                if (!in_range) begin
                    m_out   = '0;
                    m_known = 1'b1;
                end else if (I_WRITE_ENABLE) begin
                    m_out   = I_PIXEL;
                    m_known = 1'b1;
                end else if (m_mem.exists(key)) begin
                    m_out   = m_mem[key];
                    m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
            end
            if (I_WRITE_ENABLE && in_range) m_mem[key] = I_PIXEL;
        end
    end

    always @(negedge I_CLK) begin
        if (m_known) begin
            n_chk++;
            if (O_PIXEL !== m_out) begin
                n_fail++;
                $display("FAIL model t=%0t: O_PIXEL got %h, want %h", $time, O_PIXEL, m_out);
            end
        end
    end

    task automatic chk(input string name, input logic [23:0] exp);
        n_chk++;
        if (O_PIXEL !== exp) begin
            n_fail++;
            $display("FAIL %s: O_PIXEL got %h, want %h", name, O_PIXEL, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic re, input int col, input int row,
                       input logic [23:0] pix);
        I_WRITE_ENABLE = we;
        I_READ_ENABLE  = re;
        I_COLUMN       = 10'(col);
        I_ROW          = 2'(row);
        I_PIXEL        = pix;
        @(posedge I_CLK);
        #1;
    endtask

    task automatic wr(input int col, input int row, input logic [23:0] pix);
        cyc(1'b1, 1'b0, col, row, pix);
    endtask

    task automatic rd(input int col, input int row);
        cyc(1'b0, 1'b1, col, row, 24'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 24'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_RESET = 1'b0;
        I_WRITE_ENABLE = 1'b0;
        I_READ_ENABLE = 1'b0;
        I_COLUMN = '0;
        I_ROW = '0;
        I_PIXEL = '0;
        #1;
        chk("reset_initial", 24'h000000);
        idle();
        chk("reset_held", 24'h000000);
        I_RESET = 1'b1;
        idle();
        chk("idle_after_release", 24'h000000);

        wr(0, 0, 24'hFFFFFF);
        chk("write_no_read", 24'h000000);
        rd(0, 0);
        chk("read_0_0", 24'hFFFFFF);
        idle();
        chk("hold_after_re_drop", 24'hFFFFFF);

        wr(639, 2, 24'hFF0000);
        rd(639, 2);
        chk("read_639_2", 24'hFF0000);
        rd(0, 0);
        chk("reread_0_0", 24'hFFFFFF);

        wr(5, 0, 24'h0A0B0C);
        wr(60, 1, 24'h111111);
        wr(5, 3, 24'h123456);
        wr(700, 0, 24'h222222);
        rd(5, 3);
        chk("read_row3", 24'h000000);
        rd(0, 0);
        rd(700, 0);
        chk("read_col700", 24'h000000);
        rd(0, 0);
        chk("unchanged_0_0", 24'hFFFFFF);
        rd(5, 0);
        chk("unchanged_5_0", 24'h0A0B0C);
        rd(60, 1);
        chk("no_alias_60_1", 24'h111111);

        wr(10, 1, 24'h333333);
        cyc(1'b1, 1'b1, 10, 1, 24'h00FF00);
        chk("write_through", 24'h00FF00);
        rd(0, 0);
        rd(10, 1);
        chk("read_after_wt", 24'h00FF00);
        cyc(1'b1, 1'b1, 5, 3, 24'h654321);
        chk("wt_invalid", 24'h000000);

        rd(0, 0);
        chk("b2b_0", 24'hFFFFFF);
        rd(639, 2);
        chk("b2b_1", 24'hFF0000);
        rd(10, 1);
        chk("b2b_2", 24'h00FF00);

        wr(2, 2, 24'h777777);
        chk("write_only_holds", 24'h00FF00);
        wr(1, 1, 24'hABCDEF);
        rd(1, 1);
        chk("raw_next_cycle", 24'hABCDEF);
        rd(2, 2);
        chk("read_2_2", 24'h777777);

        #2;
        I_RESET = 1'b0;
        #1;
        chk("async_reset_midcycle", 24'h000000);
        wr(1, 1, 24'h999999);
        chk("reset_during_write", 24'h000000);
        I_RESET = 1'b1;
        idle();
        chk("no_read_after_reset", 24'h000000);
        rd(1, 1);
        chk("retained_1_1", 24'hABCDEF);
        rd(2, 2);
        chk("retained_2_2", 24'h777777);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Single-port, on-chip pixel store for the colorspace stage. Holds P_ROWS lines of P_COLUMNS pixels, each P_PIXEL_DEPTH bits wide.
- Upstream logic writes pixels by (column, row) address. Downstream logic reads pixels back through a registered output.
- Sits between the pixel input path and the edge-detection window logic, which reads neighbouring lines from it.

Parameters:
- P_COLUMNS, 640, pixels per row; must be >= 2.
- P_ROWS, 3, number of rows stored; must be >= 2.
- P_PIXEL_DEPTH, 24, bits per pixel (RGB, P_PIXEL_DEPTH/3 bits per subpixel, R in MSBs); must be a multiple of 3.

Ports:
- I_CLK  input  1  system clock; all state changes on the rising edge.
- I_RESET  input  1  reset; asynchronous and active-low.
- I_COLUMN  input  $clog2(P_COLUMNS)  column address (10 bits at default).
- I_ROW  input  $clog2(P_ROWS)  row address (2 bits at default).
- I_PIXEL  input  P_PIXEL_DEPTH  write data.
- I_WRITE_ENABLE  input  1  write strobe, active-high.
- I_READ_ENABLE  input  1  read strobe, active-high.
- O_PIXEL  output  P_PIXEL_DEPTH  registered read data.

Behaviour:
- Storage: P_COLUMNS*P_ROWS words of P_PIXEL_DEPTH bits. Linear index = I_ROW*P_COLUMNS + I_COLUMN (row-major).
- Address valid when I_COLUMN < P_COLUMNS AND I_ROW < P_ROWS. At defaults, row 3 and columns 640..1023 are invalid.
- Reset:
  - I_RESET low forces O_PIXEL to all zeros immediately, without waiting for a clock edge.
  - Reset does not clear storage. Contents are undefined until written and are retained across reset.
  - Writes are blocked while reset is asserted.
- Write: on a rising edge with I_RESET high, I_WRITE_ENABLE=1 and a valid address, mem[index] <= I_PIXEL. A write to an invalid address is silently dropped.
- Read:
  - On a rising edge with I_RESET high, I_READ_ENABLE=1 and I_WRITE_ENABLE=0, O_PIXEL <= mem[index].
  - Latency is 1 cycle: data is visible after the edge that samples the strobe.
  - A read from an invalid address loads O_PIXEL with all zeros.
- Simultaneous read and write (both enables 1), write-through:
  - Storage is written as above.
  - O_PIXEL <= I_PIXEL if the address is valid, else all zeros.
- Idle (I_READ_ENABLE=0, with or without a write): O_PIXEL holds its previous value.
- Enables are sampled per cycle; there is no handshake or backpressure. Back-to-back reads and writes are permitted every cycle, and consecutive reads to different addresses give one result per cycle.
- Read-after-write to the same address on the next cycle returns the new data.
- No wrap-around: the address is never auto-incremented.
- Inputs are assumed synchronous to I_CLK. There is no internal state machine.

Test Plan:
- Reset: hold I_RESET low 1 cycle -> O_PIXEL=24'h000000, also asynchronously mid-cycle. Release -> O_PIXEL stays 0 with no read.
- Write (0,0)=24'hFFFFFF with WE=1 for 1 cycle, then RE=1, WE=0 -> O_PIXEL=24'hFFFFFF one edge later. Holds after RE drops.
- Write (639,2)=24'hFF0000, then read (639,2) -> 24'hFF0000. Re-read (0,0) -> 24'hFFFFFF; no aliasing between corner locations.
- Invalid address:
  - Write row=3, col=5, data 24'h123456 -> nothing stored.
  - Read row=3 -> O_PIXEL=0.
  - Read col=700, row=0 -> 0.
  - (0,0) and (5,0) are unchanged.
- Simultaneous RE=WE=1 at (10,1), data 24'h00FF00 -> O_PIXEL=24'h00FF00 next edge. A later plain read of (10,1) -> 24'h00FF00.
- Reset mid-operation: after writing (1,1)=24'hABCDEF, pulse I_RESET low -> O_PIXEL=0. Read (1,1) after release -> 24'hABCDEF (storage retained).
